// File: rtl/sprite_select.sv
// Screen-to-sprite resolver: maps the VGA raster onto the tile grid, hit-tests frame-latched
// tank/bullet boxes and presents sprite selects and local coordinates two cycles later.
module sprite_select #(
  parameter int unsigned NUM_TANKS = 2,
  parameter int unsigned MAP_COLS  = 20,
  parameter int unsigned MAP_ROWS  = 15
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_start,
  input  logic                    draw_en,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic [10*NUM_TANKS-1:0] tank_x,
  input  logic [10*NUM_TANKS-1:0] tank_y,
  input  logic [2*NUM_TANKS-1:0]  tank_dir,
  input  logic [NUM_TANKS-1:0]    tank_alive,
  input  logic [10*NUM_TANKS-1:0] bul_x,
  input  logic [10*NUM_TANKS-1:0] bul_y,
  input  logic [NUM_TANKS-1:0]    bul_active,
  output logic [8:0]              map_addr,
  input  logic [1:0]              map_data,
  output logic [4:0]              LocX,
  output logic [4:0]              LocY,
  output logic [1:0]              dir,
  output logic                    bul,
  output logic                    brk,
  output logic                    bush,
  output logic                    rck,
  output logic                    tank_hit,
  output logic [1:0]              tank_id,
  output logic                    sprite_valid
);

  localparam logic [9:0] SCR_W  = 10'(MAP_COLS * 32);
  localparam logic [9:0] SCR_H  = 10'(MAP_ROWS * 32);
  localparam logic [8:0] COLS9  = 9'(MAP_COLS);
  localparam logic [1:0] TILE_BRICK = 2'd1;
  localparam logic [1:0] TILE_BUSH  = 2'd2;
  localparam logic [1:0] TILE_ROCK  = 2'd3;

  // 32-wide box test; a borrow (pixel left of/above the box) is a miss, never a wrap
  function automatic logic box_hit(input logic [9:0] p, input logic [9:0] o);
    logic [10:0] d;
    d = {1'b0, p} - {1'b0, o};
    return (d[10:5] == 6'd0);
  endfunction

  logic [10*NUM_TANKS-1:0] sh_tank_x, sh_tank_y, sh_bul_x, sh_bul_y;
  logic [2*NUM_TANKS-1:0]  sh_tank_dir;
  logic [NUM_TANKS-1:0]    sh_tank_alive, sh_bul_active;

  logic       in_range_c;
  logic       t_hit_c, b_hit_c;
  logic [1:0] t_id_c, t_dir_c;
  logic [4:0] t_dx_c, t_dy_c, b_dx_c, b_dy_c;

  logic       s1_valid, s1_thit, s1_bhit;
  logic [1:0] s1_tid, s1_tdir;
  logic [4:0] s1_tlx, s1_tly, s1_tdx, s1_tdy, s1_bdx, s1_bdy;

  logic       nx_valid, nx_bul, nx_brk, nx_bush, nx_rck, nx_thit;
  logic [1:0] nx_tid, nx_dir;
  logic [4:0] nx_locx, nx_locy;

  assign map_addr   = {4'd0, DrawY[9:5]} * COLS9 + {4'd0, DrawX[9:5]};
  assign in_range_c = draw_en & (DrawX < SCR_W) & (DrawY < SCR_H);

  // Object shadows only change at frame start so a frame never tears
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sh_tank_x     <= '0;
      sh_tank_y     <= '0;
      sh_tank_dir   <= '0;
      sh_tank_alive <= '0;
      sh_bul_x      <= '0;
      sh_bul_y      <= '0;
      sh_bul_active <= '0;
    end else if (frame_start) begin
      sh_tank_x     <= tank_x;
      sh_tank_y     <= tank_y;
      sh_tank_dir   <= tank_dir;
      sh_tank_alive <= tank_alive;
      sh_bul_x      <= bul_x;
      sh_bul_y      <= bul_y;
      sh_bul_active <= bul_active;
    end
  end

  // Hit tests; scanning downwards lets the lowest index win among overlaps
  always_comb begin
    t_hit_c = 1'b0;
    t_id_c  = '0;
    t_dir_c = '0;
    t_dx_c  = '0;
    t_dy_c  = '0;
    b_hit_c = 1'b0;
    b_dx_c  = '0;
    b_dy_c  = '0;
    for (int i = int'(NUM_TANKS) - 1; i >= 0; i--) begin
      if (sh_tank_alive[i] && box_hit(DrawX, sh_tank_x[10*i +: 10])
          && box_hit(DrawY, sh_tank_y[10*i +: 10])) begin
        t_hit_c = 1'b1;
        t_id_c  = 2'(i);
        t_dir_c = sh_tank_dir[2*i +: 2];
        t_dx_c  = DrawX[4:0] - sh_tank_x[10*i +: 5];
        t_dy_c  = DrawY[4:0] - sh_tank_y[10*i +: 5];
      end
      if (sh_bul_active[i] && box_hit(DrawX, sh_bul_x[10*i +: 10])
          && box_hit(DrawY, sh_bul_y[10*i +: 10])) begin
        b_hit_c = 1'b1;
        b_dx_c  = DrawX[4:0] - sh_bul_x[10*i +: 5];
        b_dy_c  = DrawY[4:0] - sh_bul_y[10*i +: 5];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_tlx   <= '0;
      s1_tly   <= '0;
      s1_thit  <= 1'b0;
      s1_tid   <= '0;
      s1_tdir  <= '0;
      s1_tdx   <= '0;
      s1_tdy   <= '0;
      s1_bhit  <= 1'b0;
      s1_bdx   <= '0;
      s1_bdy   <= '0;
    end else begin
      s1_valid <= in_range_c;
      s1_tlx   <= DrawX[4:0];
      s1_tly   <= DrawY[4:0];
      s1_thit  <= t_hit_c;
      s1_tid   <= t_id_c;
      s1_tdir  <= t_dir_c;
      s1_tdx   <= t_dx_c;
      s1_tdy   <= t_dy_c;
      s1_bhit  <= b_hit_c;
      s1_bdx   <= b_dx_c;
      s1_bdy   <= b_dy_c;
    end
  end

  // Priority: bush tile hides objects, then bullet, tank, brick, rock
  always_comb begin
    nx_valid = 1'b0;
    nx_bul   = 1'b0;
    nx_brk   = 1'b0;
    nx_bush  = 1'b0;
    nx_rck   = 1'b0;
    nx_thit  = 1'b0;
    nx_tid   = '0;
    nx_dir   = '0;
    nx_locx  = '0;
    nx_locy  = '0;
    if (s1_valid) begin
      if (map_data == TILE_BUSH) begin
        nx_valid = 1'b1;
        nx_bush  = 1'b1;
        nx_locx  = s1_tlx;
        nx_locy  = s1_tly;
      end else if (s1_bhit) begin
        nx_valid = 1'b1;
        nx_bul   = 1'b1;
        nx_locx  = s1_bdx;
        nx_locy  = s1_bdy;
      end else if (s1_thit) begin
        nx_valid = 1'b1;
        nx_thit  = 1'b1;
        nx_tid   = s1_tid;
        nx_dir   = s1_tdir;
        nx_locx  = s1_tdx;
        nx_locy  = s1_tdy;
      end else if (map_data == TILE_BRICK) begin
        nx_valid = 1'b1;
        nx_brk   = 1'b1;
        nx_locx  = s1_tlx;
        nx_locy  = s1_tly;
      end else if (map_data == TILE_ROCK) begin
        nx_valid = 1'b1;
        nx_rck   = 1'b1;
        nx_locx  = s1_tlx;
        nx_locy  = s1_tly;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sprite_valid <= 1'b0;
      bul          <= 1'b0;
      brk          <= 1'b0;
      bush         <= 1'b0;
      rck          <= 1'b0;
      tank_hit     <= 1'b0;
      tank_id      <= '0;
      dir          <= '0;
      LocX         <= '0;
      LocY         <= '0;
    end else begin
      sprite_valid <= nx_valid;
      bul          <= nx_bul;
      brk          <= nx_brk;
      bush         <= nx_bush;
      rck          <= nx_rck;
      tank_hit     <= nx_thit;
      tank_id      <= nx_tid;
      dir          <= nx_dir;
      LocX         <= nx_locx;
      LocY         <= nx_locy;
    end
  end

endmodule
